// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word layout, writeback/size encodings,
// memory-stage FSM states and the EX/MEM register payload.
package pipeline_pkg;

  localparam int unsigned CW_W         = 9;
  localparam int unsigned CW_BRANCH    = 8;
  localparam int unsigned CW_RF_WB     = 7;
  localparam int unsigned CW_MEM_WE    = 6;
  localparam int unsigned CW_WB_SRC_LO = 4;
  localparam int unsigned CW_WB_SRC_W  = 2;
  localparam int unsigned CW_PC_SRC    = 3;
  localparam int unsigned CW_FUNCT3_LO = 0;
  localparam int unsigned CW_FUNCT3_W  = 3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Fields of the accepted bundle still needed once the request is in flight.
  typedef struct packed {
    logic        rf_wb;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [1:0]  adr_lo;
    logic [31:0] alt_data;
  } exmem_t;

  // Store funct3 codes share the load size bits, so one decode serves both.
  function automatic size_t access_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      F3_LW:         return SZ_WORD;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for data-memory accesses: byte enables, store-data
// replication, load extraction/extension and alignment check.
module load_store_align
  import pipeline_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] load_c,
  output logic        misaligned_c
);

  size_t       sz;
  logic [31:0] lane;

  always_comb begin
    sz           = access_size(funct3);
    lane         = load_data >> {addr, 3'b000};
    be_c         = 4'b1111;
    wdata_c      = store_data;
    load_c       = lane;
    misaligned_c = 1'b0;
    case (sz)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr;
        wdata_c = {4{store_data[7:0]}};
        load_c  = {{24{lane[7] & ~funct3[2]}}, lane[7:0]};
      end
      SZ_HALF: begin
        be_c         = 4'b0011 << {addr[1], 1'b0};
        wdata_c      = {2{store_data[15:0]}};
        load_c       = {{16{lane[15] & ~funct3[2]}}, lane[15:0]};
        misaligned_c = addr[0];
      end
      default: misaligned_c = |addr;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: captures the execute bundle, runs loads/stores on the
// data-memory interface, raises fetch redirects and emits the writeback bundle.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   control_word_ex,
  input  logic [4:0]        rd_ex,
  input  logic [31:0]       calculated_adr,
  input  logic [31:0]       pc_plus_4_ex,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       regfileb_ex,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              wb_valid,
  output logic              wb_rf_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misaligned,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

  state_t           state;
  exmem_t           ex_q;
  logic [CNT_W-1:0] rsp_cnt;

  logic        accept, idle, in_load, in_store, in_mem, in_redirect, rsp_timeout;
  logic [31:0] in_alt;
  logic [2:0]  al_f3;
  logic [1:0]  al_adr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_mis;

  // Incoming-bundle decode; the aligner sees the live bundle in S_IDLE and
  // the held EX/MEM fields while a load response is awaited.
  always_comb begin
    accept      = in_valid & in_ready;
    idle        = (state == S_IDLE);
    in_store    = control_word_ex[CW_MEM_WE];
    in_load     = (control_word_ex[CW_WB_SRC_LO +: CW_WB_SRC_W] == WB_MEM);
    in_mem      = in_load | in_store;
    in_redirect = control_word_ex[CW_BRANCH] | control_word_ex[CW_PC_SRC];
    in_alt      = ALU_result;
    case (control_word_ex[CW_WB_SRC_LO +: CW_WB_SRC_W])
      WB_ALU:  in_alt = ALU_result;
      WB_PC4:  in_alt = pc_plus_4_ex;
      default: in_alt = ALU_result;
    endcase
    al_f3       = idle ? control_word_ex[CW_FUNCT3_LO +: CW_FUNCT3_W] : ex_q.funct3;
    al_adr      = idle ? calculated_adr[1:0] : ex_q.adr_lo;
    rsp_timeout = (RSP_TIMEOUT != 0) && (rsp_cnt == CNT_W'(RSP_TIMEOUT - 1));
  end

  load_store_align u_align (
    .funct3       (al_f3),
    .addr         (al_adr),
    .store_data   (regfileb_ex),
    .load_data    (dmem_rdata),
    .be_c         (al_be),
    .wdata_c      (al_wdata),
    .load_c       (al_load),
    .misaligned_c (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ex_q           <= '0;
      rsp_cnt        <= '0;
      in_ready       <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      wb_valid       <= 1'b0;
      wb_rf_we       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      misaligned     <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      redirect_valid <= 1'b0;
      misaligned     <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            ex_q.rf_wb     <= control_word_ex[CW_RF_WB];
            ex_q.mem_we    <= in_store;
            ex_q.funct3    <= control_word_ex[CW_FUNCT3_LO +: CW_FUNCT3_W];
            ex_q.rd        <= rd_ex;
            ex_q.adr_lo    <= calculated_adr[1:0];
            ex_q.alt_data  <= in_alt;
            redirect_valid <= in_redirect;
            redirect_pc    <= calculated_adr;
            if (in_mem && !al_mis) begin
              state      <= S_REQ;
              in_ready   <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_we    <= in_store;
              dmem_addr  <= {calculated_adr[ADDR_W-1:2], 2'b00};
              dmem_be    <= al_be;
              dmem_wdata <= al_wdata;
            end else begin
              wb_valid   <= 1'b1;
              wb_rd      <= rd_ex;
              wb_rf_we   <= control_word_ex[CW_RF_WB] & ~in_mem;
              wb_data    <= in_alt;
              misaligned <= in_mem;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (ex_q.mem_we) begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              wb_valid <= 1'b1;
              wb_rf_we <= 1'b0;
              wb_rd    <= ex_q.rd;
              wb_data  <= ex_q.alt_data;
            end else begin
              state   <= S_RSP;
              rsp_cnt <= '0;
            end
          end
        end
        S_RSP: begin
          if (dmem_rvalid) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            wb_valid <= 1'b1;
            wb_rf_we <= ex_q.rf_wb;
            wb_rd    <= ex_q.rd;
            wb_data  <= al_load;
          end else if (rsp_timeout) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            bus_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_rf_we <= 1'b0;
            wb_rd    <= ex_q.rd;
            wb_data  <= '0;
          end else if (RSP_TIMEOUT != 0) begin
            rsp_cnt <= rsp_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
